// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - video RAM arbiter for download, VDG and CPU ports
//
// Serialises access to a single-port video RAM. There are three requesters:
// a download byte latch fed by the ioctl bus, the VDG fetch port and the CPU
// port. Each access takes three cycles (IDLE sample, ACCESS, RETIRE).
//
// Ports:
//   clk_sys, reset      system clock, synchronous active-high reset
//   ioctl_*             download bus (window, target index, byte strobe, address, byte)
//   cpu_req/we/addr/din CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_dout   1-cycle completion pulse, read data valid with ack and held after
//   vdg_req/addr        VDG fetch request (level, held until vdg_ack)
//   vdg_ack, vdg_dout   1-cycle completion pulse, fetch data valid with ack and held after
//   ram_we/ad/d, ram_q  RAM port; ram_q has one cycle of registered read latency
//   dl_overrun          sticky flag: a download byte was lost
//   busy                arbiter is not IDLE
module vram_arbiter #(
   parameter int         ADDR_W       = 12,
   parameter int         DATA_W       = 8,
   parameter logic [7:0] DL_INDEX     = 8'h00,
   parameter int         CPU_MAX_WAIT = 3
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_dout,
   input  logic              vdg_req,
   input  logic [ADDR_W-1:0] vdg_addr,
   output logic              vdg_ack,
   output logic [DATA_W-1:0] vdg_dout,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_ad,
   output logic [DATA_W-1:0] ram_d,
   input  logic [DATA_W-1:0] ram_q,
   output logic              dl_overrun,
   output logic              busy
);

   localparam int WAIT_W = (CPU_MAX_WAIT < 2) ? 1 : $clog2(CPU_MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RETIRE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_DL, OWN_VDG, OWN_CPU} owner_t;

   state_t            state;
   owner_t            owner;
   logic              acc_we;
   logic [DATA_W-1:0] cpu_dout_q;
   logic [DATA_W-1:0] vdg_dout_q;
   logic              dl_pending;
   logic [ADDR_W-1:0] dl_addr;
   logic [DATA_W-1:0] dl_data;
   logic [WAIT_W-1:0] cpu_wait;

   logic dl_in_range;
   logic dl_take;
   logic grant_dl;
   logic grant_vdg;
   logic grant_cpu;

   // Bytes addressed beyond the RAM are silently discarded.
   assign dl_in_range = ((ioctl_addr >> ADDR_W) == 25'd0);
   assign dl_take     = ioctl_wr && ioctl_download && (ioctl_index == DL_INDEX) && dl_in_range;

   // Grants are only decided in IDLE. The download latch always wins; during a
   // download window CPU and VDG are held off. VDG normally beats the CPU, but
   // a CPU that has been passed over WAIT_MAX times in a row gets the slot.
   always_comb begin
      grant_dl  = 1'b0;
      grant_vdg = 1'b0;
      grant_cpu = 1'b0;
      if (state == ST_IDLE) begin
         if (dl_pending) begin
            grant_dl = 1'b1;
         end else if (!ioctl_download) begin
            if (cpu_req && (!vdg_req || (cpu_wait == WAIT_MAX)))
               grant_cpu = 1'b1;
            else if (vdg_req)
               grant_vdg = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= ST_IDLE;
         owner      <= OWN_NONE;
         acc_we     <= 1'b0;
         ram_we     <= 1'b0;
         ram_ad     <= '0;
         ram_d      <= '0;
         cpu_ack    <= 1'b0;
         vdg_ack    <= 1'b0;
         cpu_dout_q <= '0;
         vdg_dout_q <= '0;
         dl_pending <= 1'b0;
         dl_addr    <= '0;
         dl_data    <= '0;
         dl_overrun <= 1'b0;
         cpu_wait   <= '0;
      end else begin
         cpu_ack <= 1'b0;
         vdg_ack <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (grant_dl) begin
                  state  <= ST_ACCESS;
                  owner  <= OWN_DL;
                  acc_we <= 1'b1;
                  ram_we <= 1'b1;
                  ram_ad <= dl_addr;
                  ram_d  <= dl_data;
               end else if (grant_cpu) begin
                  state  <= ST_ACCESS;
                  owner  <= OWN_CPU;
                  acc_we <= cpu_we;
                  ram_we <= cpu_we;
                  ram_ad <= cpu_addr;
                  ram_d  <= cpu_din;
               end else if (grant_vdg) begin
                  state  <= ST_ACCESS;
                  owner  <= OWN_VDG;
                  acc_we <= 1'b0;
                  ram_we <= 1'b0;
                  ram_ad <= vdg_addr;
               end
            end
            ST_ACCESS: begin
               state   <= ST_RETIRE;
               ram_we  <= 1'b0;
               cpu_ack <= (owner == OWN_CPU);
               vdg_ack <= (owner == OWN_VDG);
            end
            ST_RETIRE: begin
               state <= ST_IDLE;
               if (cpu_ack && !acc_we)
                  cpu_dout_q <= ram_q;
               if (vdg_ack)
                  vdg_dout_q <= ram_q;
            end
            default: state <= ST_IDLE;
         endcase

         if (!cpu_req || grant_cpu)
            cpu_wait <= '0;
         else if (grant_vdg && (cpu_wait != WAIT_MAX))
            cpu_wait <= cpu_wait + 1'b1;

         // A byte arriving in the same cycle the latch is granted simply
         // refills it; only a byte arriving while the latch is still full is lost.
         if (dl_take) begin
            if (dl_pending && !grant_dl) begin
               dl_overrun <= 1'b1;
            end else begin
               dl_pending <= 1'b1;
               dl_addr    <= ioctl_addr[ADDR_W-1:0];
               dl_data    <= DATA_W'(ioctl_dout);
            end
         end else if (grant_dl) begin
            dl_pending <= 1'b0;
         end
      end
   end

   // ram_q only arrives in RETIRE, the same cycle the ack is high, so read
   // data is forwarded straight from the RAM during the ack and held in the
   // capture register afterwards.
   assign cpu_dout = (cpu_ack && !acc_we) ? ram_q : cpu_dout_q;
   assign vdg_dout = vdg_ack ? ram_q : vdg_dout_q;
   assign busy     = (state != ST_IDLE);

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, video RAM address width.
REQ-002 Parameter DATA_W, default 8, video RAM data width.
REQ-003 Parameter DL_INDEX, default 8'h00, ioctl_index value that targets video RAM.
REQ-004 Parameter CPU_MAX_WAIT, default 3, consecutive VDG grants tolerated while CPU waits.
REQ-005 The block SHALL use one clock, clk_sys; reset is synchronous and active-high, named reset.
REQ-006 Ports (name  direction  width  meaning) SHALL be:
 clk_sys  in  1  system clock
 reset  in  1  synchronous active-high reset
 ioctl_download  in  1  download window active
 ioctl_index  in  8  download target select
 ioctl_wr  in  1  download byte strobe, 1-cycle pulse
 ioctl_addr  in  25  download byte address
 ioctl_dout  in  8  download byte
 cpu_req  in  1  CPU access request, level, held until cpu_ack
 cpu_we  in  1  CPU write when 1, read when 0
 cpu_addr  in  ADDR_W  CPU address
 cpu_din  in  DATA_W  CPU write data
 cpu_ack  out  1  CPU access complete, 1-cycle pulse
 cpu_dout  out  DATA_W  CPU read data, valid with cpu_ack, held after
 vdg_req  in  1  VDG fetch request, level, held until vdg_ack
 vdg_addr  in  ADDR_W  VDG fetch address
 vdg_ack  out  1  VDG fetch complete, 1-cycle pulse
 vdg_dout  out  DATA_W  VDG fetch data, valid with vdg_ack, held after
 ram_we  out  1  RAM write enable
 ram_ad  out  ADDR_W  RAM address
 ram_d  out  DATA_W  RAM write data
 ram_q  in  DATA_W  RAM read data, 1-cycle registered latency
 dl_overrun  out  1  sticky: download byte lost
 busy  out  1  state not IDLE

Function
REQ-007 FSM states IDLE, ACCESS, RETIRE; IDLE->ACCESS on any grant; ACCESS->RETIRE; RETIRE->IDLE unconditionally.
REQ-008 Requests SHALL be sampled only in IDLE; one access per 3 cycles maximum throughput.
REQ-009 On grant, ram_ad, ram_d and ram_we SHALL be registered so they are valid for exactly the ACCESS cycle; ram_we=1 only in ACCESS for write grants, else 0.
REQ-010 In RETIRE, ram_q SHALL be captured into the winner's dout and the winner's ack pulsed for that single cycle; ack is high exactly 2 cycles after the IDLE sampling cycle.
REQ-011 A write grant SHALL still pulse ack in RETIRE; dout unchanged on writes.
REQ-012 Download latch: ioctl_wr with ioctl_download=1 and ioctl_index=DL_INDEX SHALL set dl_pending and capture address and data.
REQ-013 A download byte with ioctl_addr >= 2**ADDR_W SHALL be discarded without setting dl_pending.
REQ-014 ioctl_wr while dl_pending=1 and not cleared that same cycle SHALL set dl_overrun; latched byte retained, new byte dropped.
REQ-015 Priority in IDLE: dl_pending > VDG > CPU, except CPU beats VDG when cpu_wait = CPU_MAX_WAIT.
REQ-016 dl_pending SHALL clear on its grant; a grant and a new ioctl_wr in the same cycle SHALL re-set dl_pending with the new byte, no overrun.
REQ-017 While ioctl_download=1, CPU and VDG SHALL receive no grants; their requests stay pending.
REQ-018 cpu_wait (saturating) SHALL increment on each VDG grant while cpu_req=1, clear on CPU grant or when cpu_req=0.
REQ-019 Simultaneous cpu_req and vdg_req with cpu_wait < CPU_MAX_WAIT SHALL grant VDG.
REQ-020 Address/data inputs SHALL be sampled only at grant; changes afterwards have no effect on the access.

Reset
REQ-021 Reset in any state SHALL force IDLE, ram_we=0, ram_ad=0, ram_d=0, cpu_ack=0, vdg_ack=0, cpu_dout=0, vdg_dout=0, dl_pending=0, dl_overrun=0, cpu_wait=0, busy=0.
REQ-022 An access interrupted by reset SHALL not be acked; a write in ACCESS during the reset cycle SHALL not reach RAM (ram_we forced 0 from next cycle, reset cycle's ram_we already issued is permitted).
REQ-023 dl_overrun SHALL clear only on reset.

Verification
REQ-024 CPU write addr 12'h123 data 8'hA5, then CPU read 12'h123 -> ram_we=1 one cycle, cpu_ack 2 cycles after sample, read cpu_dout=8'hA5.
REQ-025 cpu_req and vdg_req held continuously -> grant order V,V,V,C,V,V,V,C (CPU_MAX_WAIT=3); no ack overlap.
REQ-026 ioctl_download=1, ioctl_wr every 4 cycles, addr 0..15, data=addr^8'h5A -> 16 RAM writes, dl_overrun=0, CPU/VDG acks absent.
REQ-027 ioctl_wr on two consecutive cycles while grant blocked -> dl_overrun=1, first byte written only; addr 25'h1000 -> no write.
REQ-028 Reset asserted during ACCESS of CPU read -> no cpu_ack, all outputs at REQ-021 values next cycle, busy=0.
REQ-029 vdg_req only, addr sweep 0..4095 -> 4096 vdg_acks, vdg_dout matches preloaded RAM image.
